// File: rtl/coin_credit_ctrl.sv
// Coin-operated charger credit controller.
// Tracks coin credit, runs the charge timer, and signals done.
module coin_credit_ctrl #(
  parameter int SEC_PER_YUAN = 60,
  parameter int MAX_CREDIT   = 20,
  parameter int IDLE_TIMEOUT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        coin1,
  input  logic        coin5,
  input  logic        start,
  input  logic        cancel,
  output logic        charging,
  output logic [4:0]  credit,
  output logic [10:0] remaining,
  output logic        reject,
  output logic        done
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [5:0]  MAXC = 6'(MAX_CREDIT);
  localparam logic [10:0] SEC  = 11'(SEC_PER_YUAN);
  localparam logic [TW-1:0] TLAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INPUT,
    S_CHARGING,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [4:0]      credit_n;
  logic [10:0]     rem_n;
  logic            rej_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic [1:0]      dcnt, dcnt_n;

  logic            ok5, ok1;
  logic [4:0]      c5, c1;
  logic            coin_any, coin_rej;

  assign charging = (state == S_CHARGING);
  assign done     = (state == S_DONE);

  // coin5 is judged first, then coin1 against the updated credit
  always_comb begin
    ok5      = coin5 && (({1'b0, credit} + 6'd5) <= MAXC);
    c5       = ok5 ? credit + 5'd5 : credit;
    ok1      = coin1 && (({1'b0, c5} + 6'd1) <= MAXC);
    c1       = ok1 ? c5 + 5'd1 : c5;
    coin_any = coin1 | coin5;
    coin_rej = (coin5 & ~ok5) | (coin1 & ~ok1);
  end

  // state register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      credit    <= '0;
      remaining <= '0;
      reject    <= 1'b0;
      tmo       <= '0;
      dcnt      <= '0;
    end else begin
      state     <= state_n;
      credit    <= credit_n;
      remaining <= rem_n;
      reject    <= rej_n;
      tmo       <= tmo_n;
      dcnt      <= dcnt_n;
    end
  end

  // next-state and datapath decisions
  always_comb begin
    state_n  = state;
    credit_n = credit;
    rem_n    = remaining;
    rej_n    = 1'b0;
    tmo_n    = tmo;
    dcnt_n   = dcnt;
    unique case (state)
      S_IDLE: begin
        rem_n = '0;
        if (cancel) begin
          rej_n = coin_any;
        end else if (coin_any) begin
          credit_n = c1;
          rem_n    = {6'd0, c1} * SEC;
          rej_n    = coin_rej;
          tmo_n    = '0;
          state_n  = S_INPUT;
        end
      end
      S_INPUT: begin
        if (cancel) begin
          credit_n = '0;
          rem_n    = '0;
          rej_n    = 1'b1;
          tmo_n    = '0;
          state_n  = S_IDLE;
        end else if (start && credit != '0) begin
          credit_n = '0;
          rem_n    = {6'd0, credit} * SEC;
          rej_n    = coin_any;
          tmo_n    = '0;
          state_n  = S_CHARGING;
        end else if (coin_any) begin
          credit_n = c1;
          rem_n    = {6'd0, c1} * SEC;
          rej_n    = coin_rej;
          tmo_n    = '0;
        end else if (start) begin
          tmo_n = '0;
        end else if (tick) begin
          if (tmo == TLAST) begin
            credit_n = '0;
            rem_n    = '0;
            tmo_n    = '0;
            state_n  = S_IDLE;
          end else begin
            tmo_n = tmo + 1'b1;
          end
        end
      end
      S_CHARGING: begin
        rej_n = coin_any;
        if (tick) begin
          if (remaining <= 11'd1) begin
            rem_n   = '0;
            dcnt_n  = '0;
            state_n = S_DONE;
          end else begin
            rem_n = remaining - 11'd1;
          end
        end
      end
      S_DONE: begin
        rej_n = coin_any;
        rem_n = '0;
        if (tick) begin
          if (dcnt == 2'd2) begin
            dcnt_n  = '0;
            state_n = S_IDLE;
          end else begin
            dcnt_n = dcnt + 2'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Directed bench for coin_credit_ctrl.
// Vectors with hand-computed expectations.
module tb_coin_credit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick, coin1, coin5, start, cancel;
  logic        charging;
  logic [4:0]  credit;
  logic [10:0] remaining;
  logic        reject;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  coin_credit_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .coin1     (coin1),
    .coin5     (coin5),
    .start     (start),
    .cancel    (cancel),
    .charging  (charging),
    .credit    (credit),
    .remaining (remaining),
    .reject    (reject),
    .done      (done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // one cycle of stimulus, driven and cleared on falling edges
  task automatic cyc(input logic c1, input logic c5, input logic st,
                     input logic cn, input logic tk);
    coin1  = c1;
    coin5  = c5;
    start  = st;
    cancel = cn;
    tick   = tk;
    @(negedge clk);
    coin1  = 1'b0;
    coin5  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    tick   = 1'b0;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 1);
      idle_cyc();
    end
  endtask

  initial begin
    reset = 1'b0;
    {tick, coin1, coin5, start, cancel} = '0;
    repeat (3) @(negedge clk);
    chk("rst_credit", credit, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_chg", charging, 0);
    chk("rst_rej", reject, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    cyc(1, 0, 0, 0, 0);
    chk("c1_credit", credit, 1);
    chk("c1_rem", remaining, 60);
    chk("c1_rej", reject, 0);
    cyc(0, 1, 0, 0, 0);
    chk("c5_credit", credit, 6);
    chk("c5_rem", remaining, 360);
    cyc(0, 0, 1, 0, 0);
    chk("st_chg", charging, 1);
    chk("st_rem", remaining, 360);
    chk("st_credit", credit, 0);

    cyc(1, 0, 0, 0, 0);
    chk("chg_coin_rej", reject, 1);
    chk("chg_coin_credit", credit, 0);
    idle_cyc();
    chk("chg_rej_pulse", reject, 0);
    cyc(0, 0, 0, 1, 0);
    chk("chg_cancel_ign", charging, 1);

    ticks(358);
    chk("rem2", remaining, 2);
    cyc(0, 0, 0, 0, 1);
    chk("rem1", remaining, 1);
    chk("rem1_chg", charging, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rem0", remaining, 0);
    chk("rem0_chg", charging, 0);
    chk("done_t0", done, 1);
    cyc(0, 0, 0, 0, 1);
    chk("done_t1", done, 1);
    cyc(0, 0, 0, 0, 1);
    chk("done_t2", done, 1);
    cyc(0, 0, 0, 0, 1);
    chk("done_end", done, 0);
    chk("done_end_chg", charging, 0);
    cyc(0, 0, 1, 0, 0);
    chk("idle_start_ign", charging, 0);

    repeat (3) cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("cr18", credit, 18);
    cyc(0, 1, 0, 0, 0);
    chk("sat_rej", reject, 1);
    chk("sat_credit", credit, 18);
    cyc(1, 0, 0, 0, 0);
    chk("cr19", credit, 19);
    chk("cr19_rej", reject, 0);
    cyc(0, 0, 0, 1, 0);
    chk("cancel_credit", credit, 0);
    chk("cancel_rem", remaining, 0);
    chk("cancel_rej", reject, 1);

    repeat (3) cyc(0, 1, 0, 0, 0);
    chk("cr15", credit, 15);
    cyc(1, 1, 0, 0, 0);
    chk("both_credit", credit, 20);
    chk("both_rej", reject, 1);
    idle_cyc();
    chk("both_rej_once", reject, 0);
    cyc(0, 0, 0, 1, 0);

    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("cr3", credit, 3);
    cyc(0, 0, 1, 1, 0);
    chk("cs_credit", credit, 0);
    chk("cs_rej", reject, 1);
    chk("cs_chg", charging, 0);
    idle_cyc();
    chk("cs_chg_after", charging, 0);

    repeat (2) cyc(1, 0, 0, 0, 0);
    ticks(9);
    chk("to9_credit", credit, 2);
    cyc(0, 0, 0, 0, 1);
    chk("to10_credit", credit, 0);
    chk("to10_rem", remaining, 0);
    chk("to10_rej", reject, 0);

    cyc(1, 0, 0, 0, 0);
    ticks(9);
    cyc(1, 0, 0, 0, 1);
    chk("tkcoin_credit", credit, 2);
    ticks(9);
    chk("tkcoin9_credit", credit, 2);
    cyc(0, 0, 0, 0, 1);
    chk("tkcoin10_credit", credit, 0);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(5);
    chk("mid_rem", remaining, 55);
    chk("mid_chg", charging, 1);
    #3 reset = 1'b0;
    #2;
    chk("arst_chg", charging, 0);
    chk("arst_rem", remaining, 0);
    chk("arst_rej", reject, 0);
    @(negedge clk);
    reset = 1'b1;
    idle_cyc();
    chk("arst_after_credit", credit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
